relu_pool_serializer: RTL and testbench

Post-convolution stage that sits directly downstream of each convolution unit. It accepts the full parallel vector of convolution results in one handshake. It applies ReLU and 1-D max-pooling to the vector, then streams the pooled words one per cycle into the serial valid/ready input of the next layer. It double-acts as the decoupling buffer between layers: the convolution unit is released as soon as its vector is captured.

---
 rtl/relu_pool_serializer.sv | 87 ++++++++
 tb/tb_relu_pool_serializer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool_serializer.sv
// relu_pool_serializer: captures a conv output vector, max-pools it and streams pooled words one per cycle.
// Optional ReLU at capture is enabled by defining RELU_EN.
module relu_pool_serializer #(
    parameter int NUM_INPUTS = 2,
    parameter int WORD_SIZE  = 16,
    parameter int POOL_SIZE  = 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 valid_i,
    output logic                                 yumi_o,
    input  logic [NUM_INPUTS-1:0][WORD_SIZE-1:0] data_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [WORD_SIZE-1:0]                 data_o,
    output logic                                 last_o
);
    localparam int POOL = (POOL_SIZE < 1) ? 1 : POOL_SIZE;
    localparam int NUM_OUT = NUM_INPUTS / POOL;
    localparam int IDX_W = $clog2(NUM_OUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    if (POOL_SIZE < 1 || NUM_INPUTS % POOL != 0) begin : g_bad_cfg
        $error("POOL_SIZE must be >= 1 and divide NUM_INPUTS");
    end

    typedef enum logic {eEMPTY, eSEND} state_e;

    state_e                               ps_q, ps_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [NUM_INPUTS-1:0][WORD_SIZE-1:0] buf_q, buf_d;
    logic [NUM_OUT-1:0][WORD_SIZE-1:0]    pool_max;
    logic                                 at_last, fire;

    // Handshakes and next state; a new vector is accepted while the last word of the old one leaves.
    always_comb begin
        valid_o = (ps_q == eSEND);
        at_last = valid_o && (idx_q == LAST_IDX);
        fire    = valid_o && ready_i;
        yumi_o  = !reset_i && valid_i && (ps_q == eEMPTY || (fire && at_last));
        ps_d    = ps_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (yumi_o) begin
            ps_d  = eSEND;
            idx_d = '0;
            buf_d = data_i;
`ifdef RELU_EN
            for (int k = 0; k < NUM_INPUTS; k++)
                if (data_i[k][WORD_SIZE-1]) buf_d[k] = '0;
`endif
        end else if (fire) begin
            ps_d  = at_last ? eEMPTY : eSEND;
            idx_d = at_last ? '0 : idx_q + 1'b1;
        end
    end

    // Signed maximum over each non-overlapping pooling window of the holding register.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            pool_max[o] = buf_q[o*POOL];
            for (int j = 1; j < POOL; j++)
                if ($signed(buf_q[o*POOL+j]) > $signed(pool_max[o])) pool_max[o] = buf_q[o*POOL+j];
        end
    end

    // Select the current pooled word; outputs are zero when nothing is being offered.
    always_comb begin
        data_o = '0;
        for (int o = 0; o < NUM_OUT; o++)
            if (valid_o && idx_q == IDX_W'(o)) data_o = pool_max[o];
        last_o = at_last;
    end

    // State, index and holding register; reset discards any in-flight vector.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ps_q  <= eEMPTY;
            idx_q <= '0;
            buf_q <= '0;
        end else begin
            ps_q  <= ps_d;
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end
endmodule

// File: tb/tb_relu_pool_serializer.sv
// tb_relu_pool_serializer: scoreboard bench for the 4-in/pool-2 configuration plus a 2-in/pool-1 pass-through instance.
module tb_relu_pool_serializer;
    typedef logic [3:0][15:0] vec_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b0;
    vec_t        data_i = '0;
    logic        yumi_o, valid_o, last_o;
    logic [15:0] data_o;

    logic              pt_valid_i = 1'b0, pt_ready_i = 1'b1;
    logic [1:0][15:0]  pt_data_i = '0;
    logic              pt_yumi_o, pt_valid_o, pt_last_o;
    logic [15:0]       pt_data_o;

    int checks = 0;
    int failures = 0;
    logic [16:0] q[$];

    always #5 clk = ~clk;

    relu_pool_serializer #(.NUM_INPUTS(4), .WORD_SIZE(16), .POOL_SIZE(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .yumi_o(yumi_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o)
    );

    relu_pool_serializer #(.NUM_INPUTS(2), .WORD_SIZE(16), .POOL_SIZE(1)) u_pt (
        .clk_i(clk), .reset_i(reset_i), .valid_i(pt_valid_i), .yumi_o(pt_yumi_o), .data_i(pt_data_i),
        .valid_o(pt_valid_o), .ready_i(pt_ready_i), .data_o(pt_data_o), .last_o(pt_last_o)
    );

    function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3);
        vec_t v;
        v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3;
        return v;
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] w);
`ifdef RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    task automatic push_vec(input vec_t v);
        for (int o = 0; o < 2; o++) begin
            logic [15:0] a, b;
            a = relu(v[2*o]);
            b = relu(v[2*o+1]);
            q.push_back({o == 1, ($signed(a) > $signed(b)) ? a : b});
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Every accepted output word is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!reset_i && valid_o && ready_i) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL stream_unexpected got data=%h last=%b required no word", data_o, last_o);
            end else begin
                logic [16:0] e;
                e = q.pop_front();
                if ({last_o, data_o} !== e) begin
                    failures++;
                    $display("FAIL stream got data=%h last=%b required data=%h last=%b", data_o, last_o, e[15:0], e[16]);
                end
            end
        end
    end

    task automatic test_reset;
        valid_i = 1'b1;
        data_i = mk(16'h0100, 16'h0300, 16'hFF00, 16'h0080);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, yumi_o, data_o, last_o} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b yumi=%b data=%h last=%b required all 0", valid_o, yumi_o, data_o, last_o);
        end
        checks++;
        if (dut.idx_q !== '0 || dut.buf_q !== '0) begin
            failures++;
            $display("FAIL reset_state got idx=%0d buf=%h required 0", dut.idx_q, dut.buf_q);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic test_basic;
        step();
        data_i = mk(16'h0100, 16'h0300, 16'hFF00, 16'h0080);
        valid_i = 1'b1;
        ready_i = 1'b1;
        push_vec(data_i);
        @(negedge clk);
        checks++;
        if ({yumi_o, valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL basic_capture got yumi=%b valid=%b required yumi=1 valid=0", yumi_o, valid_o);
        end
        step();
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== {1'b1, 16'h0300, 1'b0}) begin
            failures++;
            $display("FAIL basic_word0 got valid=%b data=%h last=%b required 1 0300 0", valid_o, data_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== {1'b1, 16'h0080, 1'b1}) begin
            failures++;
            $display("FAIL basic_word1 got valid=%b data=%h last=%b required 1 0080 1", valid_o, data_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== 18'h0) begin
            failures++;
            $display("FAIL basic_idle got valid=%b data=%h last=%b required 0 0000 0", valid_o, data_o, last_o);
        end
    endtask

    task automatic test_negative;
        logic [15:0] e0, e1;
`ifdef RELU_EN
        e0 = 16'h0000; e1 = 16'h0000;
`else
        e0 = 16'hFFFF; e1 = 16'hF000;
`endif
        step();
        data_i = mk(16'h8000, 16'hFFFF, 16'hF000, 16'hC000);
        valid_i = 1'b1;
        push_vec(data_i);
        @(negedge clk);
        checks++;
        if (yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL neg_capture got yumi=%b required 1", yumi_o);
        end
        step();
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, data_o} !== {1'b1, e0}) begin
            failures++;
            $display("FAIL neg_word0 got valid=%b data=%h required 1 %h", valid_o, data_o, e0);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== {1'b1, e1, 1'b1}) begin
            failures++;
            $display("FAIL neg_word1 got valid=%b data=%h last=%b required 1 %h 1", valid_o, data_o, last_o, e1);
        end
        step();
    endtask

    task automatic test_backpressure;
        vec_t b;
        b = mk(16'h0005, 16'h0007, 16'h0009, 16'h0002);
        step();
        data_i = mk(16'h0100, 16'h0300, 16'hFF00, 16'h0080);
        valid_i = 1'b1;
        ready_i = 1'b1;
        push_vec(data_i);
        step();
        ready_i = 1'b0;
        data_i = b;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({valid_o, data_o, last_o, yumi_o} !== {1'b1, 16'h0300, 1'b0, 1'b0} || dut.idx_q !== '0) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b data=%h last=%b yumi=%b idx=%0d required 1 0300 0 0 idx 0",
                         i, valid_o, data_o, last_o, yumi_o, dut.idx_q);
            end
            step();
        end
        ready_i = 1'b1;
        push_vec(b);
        @(negedge clk);
        checks++;
        if (yumi_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_w0 got yumi=%b required 0", yumi_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({data_o, last_o, yumi_o} !== {16'h0080, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bp_release_w1 got data=%h last=%b yumi=%b required 0080 1 1", data_o, last_o, yumi_o);
        end
        step();
        valid_i = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle got valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_back_to_back;
        step();
        data_i = mk(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        valid_i = 1'b1;
        ready_i = 1'b1;
        push_vec(data_i);
        @(negedge clk);
        checks++;
        if ({yumi_o, valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_first got yumi=%b valid=%b required 1 0", yumi_o, valid_o);
        end
        step();
        data_i = mk(16'h7FFF, 16'h8000, 16'h0001, 16'h0000);
        push_vec(data_i);
        @(negedge clk);
        checks++;
        if ({valid_o, yumi_o} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_c0 got valid=%b yumi=%b required 1 0", valid_o, yumi_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, yumi_o, last_o} !== 3'b111) begin
            failures++;
            $display("FAIL b2b_c1 got valid=%b yumi=%b last=%b required 1 1 1", valid_o, yumi_o, last_o);
        end
        step();
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, yumi_o, last_o} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_d0 got valid=%b yumi=%b last=%b required 1 0 0", valid_o, yumi_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, last_o} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_d1 got valid=%b last=%b required 1 1", valid_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_reset_mid;
        step();
        data_i = mk(16'h0100, 16'h0300, 16'hFF00, 16'h0080);
        valid_i = 1'b1;
        ready_i = 1'b1;
        push_vec(data_i);
        step();
        valid_i = 1'b0;
        step();
        #2;
        reset_i = 1'b1;
        q.delete();
        data_i = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        valid_i = 1'b1;
        #1;
        checks++;
        if ({valid_o, data_o, last_o, yumi_o} !== 19'h0) begin
            failures++;
            $display("FAIL rst_mid got valid=%b data=%h last=%b yumi=%b required all 0", valid_o, data_o, last_o, yumi_o);
        end
        step();
        reset_i = 1'b0;
        push_vec(data_i);
        @(negedge clk);
        checks++;
        if (yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_recapture got yumi=%b required 1", yumi_o);
        end
        step();
        valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== {1'b1, 16'h0002, 1'b0}) begin
            failures++;
            $display("FAIL rst_word0 got valid=%b data=%h last=%b required 1 0002 0", valid_o, data_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, last_o} !== {1'b1, 16'h0004, 1'b1}) begin
            failures++;
            $display("FAIL rst_word1 got valid=%b data=%h last=%b required 1 0004 1", valid_o, data_o, last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle got valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_pass_through;
        step();
        pt_data_i[0] = 16'h0010;
        pt_data_i[1] = 16'h0020;
        pt_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (pt_yumi_o !== 1'b1) begin
            failures++;
            $display("FAIL pt_capture got yumi=%b required 1", pt_yumi_o);
        end
        step();
        pt_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({pt_valid_o, pt_data_o, pt_last_o} !== {1'b1, 16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL pt_word0 got valid=%b data=%h last=%b required 1 0010 0", pt_valid_o, pt_data_o, pt_last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({pt_valid_o, pt_data_o, pt_last_o} !== {1'b1, 16'h0020, 1'b1}) begin
            failures++;
            $display("FAIL pt_word1 got valid=%b data=%h last=%b required 1 0020 1", pt_valid_o, pt_data_o, pt_last_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (pt_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL pt_idle got valid=%b required 0", pt_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_pass_through();
        step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending words required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no completion required finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
